adg732_scan_sequencer: RTL and testbench
========================================

Name: adg732_scan_sequencer

Overview:
- Sequences the ADG732 32:1 analog mux interface (chip select, write strobe, 5-bit address, switch enable) through a programmable set of channels.
- Each channel gets a fixed dwell time; one-shot or continuous scan.
- Sits between host-side configuration (mask, dwell, start/stop) and the mux pins, in place of hand-driven cs/wr/set_ch.
- Emits a per-channel valid pulse so downstream sampling logic can align to switch events.

Parameters:
- PHASE, 4, clk cycles for each write phase (setup, strobe, hold); legal 1..255.
- DWELL_W, 24, width of the dwell_ticks input.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to begin a scan; ignored while busy
- stop  in  1  request to end the scan at next safe boundary
- continuous  in  1  1 = wrap and rescan forever, 0 = single pass; sampled at start
- ch_mask  in  32  bit i = 1 includes channel i; sampled at start
- dwell_ticks  in  DWELL_W  dwell length in clk cycles; sampled at start; 0 treated as 1
- busy  out  1  high from the cycle after accepted start until return to IDLE
- cur_ch  out  5  channel currently connected (last latched address)
- ch_valid  out  1  one-cycle pulse on the first DWELL cycle of each channel
- done  out  1  one-cycle pulse on scan end (normal or stop)
- cs_n  out  1  ADG732 chip select, active-low
- wr_n  out  1  ADG732 write strobe, active-low; address latched on its rising edge
- en_n  out  1  ADG732 enable, active-low (0 = selected switch closed)
- addr  out  5  ADG732 address A4..A0

Behaviour:
- Reset values: busy=0, cur_ch=0, ch_valid=0, done=0, cs_n=1, wr_n=1, en_n=1, addr=0, state IDLE, stop_pend=0.
- States: IDLE, SEARCH, SETUP, STROBE, HOLD, DWELL.
- IDLE:
  - start=1 and stop=0 at edge k: snapshot mask/dwell/continuous; SEARCH in cycle k+1; search base = "from channel 0 inclusive".
  - start and stop in the same cycle: remain IDLE, no done.
- SEARCH (exactly 1 cycle):
  - Next channel = lowest set bit with index > cur_ch (first search: >= 0).
  - No such bit and continuous=1: wrap to the lowest set bit overall.
  - No such bit and continuous=0, or snapshot mask = 0: go to IDLE, done pulse, en_n=1.
  - Otherwise drive addr = next channel and go to SETUP.
- Write timing:
  - SETUP: PHASE cycles, cs_n=0, wr_n=1, addr stable.
  - STROBE: PHASE cycles, cs_n=0, wr_n=0.
  - HOLD: PHASE cycles, cs_n=0, wr_n=1, addr still stable. The rising edge of wr_n at HOLD entry is the latch event.
  - At the end of HOLD: cur_ch=addr, en_n=0 (stays 0 until scan end), go to DWELL.
- DWELL:
  - dwell_ticks cycles; cs_n=1, wr_n=1.
  - ch_valid=1 on the first cycle only.
  - At the end, go to SEARCH.
- Channel period = 1 + 3*PHASE + dwell cycles.
- Single-set-bit mask with continuous=1: channel rewritten every period. No skip optimisation.
- Stop handling:
  - stop sets stop_pend in any non-IDLE state.
  - Honoured at the end of HOLD (after the latch), on any DWELL cycle, or in SEARCH.
  - stop asserted during SETUP: the write still completes, so no partial strobe is ever issued.
  - On honour: IDLE next cycle, done pulse, en_n=1, cs_n=1, wr_n=1. cur_ch retains its value.
- Input sampling: start while busy is ignored. Changes to ch_mask, dwell_ticks or continuous mid-scan have no effect until the next start.
- Dwell counter: counts in DWELL_W bits; down-count from the loaded value to 1, with no wrap.
- Reset mid-operation: synchronous. All outputs take reset values on the next edge, including cs_n and wr_n rising together. Device latch state is then undefined, but en_n=1 keeps all switches open.
- done and ch_valid never assert in the same cycle.
- busy falls in the same cycle done pulses.

Test Plan:
- PHASE=2, dwell=3, mask=0x00000005, continuous=0, start at cycle 0:
  - SEARCH c1; wr_n low c4-5; ch_valid c8 with cur_ch=0.
  - Second write wr_n low c14-15; ch_valid c18 with cur_ch=2.
  - done c22; en_n=0 c8-c21.
- mask=0x80000001, continuous=1, dwell=1:
  - cur_ch sequence 0,31,0,31…, wrapping from 31 to 0.
  - ch_valid exactly every 8 cycles (PHASE=2).
- mask=0, start -> done pulse one cycle after SEARCH; cs_n, wr_n, en_n stay 1 throughout.
- stop during STROBE:
  - wr_n completes its low phase and rises; cur_ch updates after HOLD.
  - IDLE and done on the next cycle; no ch_valid; en_n returns to 1.
- dwell_ticks=0 behaves as 1 (period = 1+3*PHASE+1). start pulsed while busy changes nothing.
- rst asserted mid-DWELL with en_n=0 -> next cycle all outputs at reset values, busy=0, no done; a subsequent start scans from channel 0.

Source files
------------

// File: rtl/adg732_scan_sequencer.sv
// Walks an ADG732 32:1 mux through the channels set in a snapshot mask: SETUP/STROBE/HOLD write per channel, then a dwell.
// All pin outputs are registered; stop is deferred to a safe boundary so a strobe is never cut short.
module adg732_scan_sequencer #(
   parameter int PHASE   = 4,
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [31:0]        ch_mask,
   input  logic [DWELL_W-1:0] dwell_ticks,
   output logic               busy,
   output logic [4:0]         cur_ch,
   output logic               ch_valid,
   output logic               done,
   output logic               cs_n,
   output logic               wr_n,
   output logic               en_n,
   output logic [4:0]         addr
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEARCH, S_SETUP, S_STROBE, S_HOLD, S_DWELL
   } state_t;

   localparam logic [7:0] PH = 8'(PHASE);

   state_t             r_state;
   logic [31:0]        r_mask;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] r_dcnt;
   logic [7:0]         r_pcnt;
   logic               r_cont;
   logic               r_first;
   logic               r_stop_pend;
   logic               r_busy;
   logic [4:0]         r_cur_ch;
   logic               r_ch_valid;
   logic               r_done;
   logic               r_cs_n;
   logic               r_wr_n;
   logic               r_en_n;
   logic [4:0]         r_addr;

   logic               w_up;
   logic [4:0]         w_up_ch;
   logic               w_any;
   logic [4:0]         w_wrap_ch;
   logic               w_stop;
   logic               w_phase_last;
   logic               w_end;

   // Descending loop so the last hit is the lowest qualifying bit.
   always_comb begin
      w_up      = 1'b0;
      w_up_ch   = 5'd0;
      w_any     = 1'b0;
      w_wrap_ch = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (r_mask[i]) begin
            w_any     = 1'b1;
            w_wrap_ch = 5'(i);
            if (r_first || (5'(i) > r_cur_ch)) begin
               w_up    = 1'b1;
               w_up_ch = 5'(i);
            end
         end
      end
   end

   assign w_stop       = r_stop_pend | stop;
   assign w_phase_last = (r_pcnt == 8'd1);

   always_comb begin
      w_end = 1'b0;
      case (r_state)
         S_SEARCH: w_end = w_stop | ~w_any | (~w_up & ~r_cont);
         S_HOLD:   w_end = w_phase_last & w_stop;
         S_DWELL:  w_end = w_stop;
         default:  w_end = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_mask      <= '0;
         r_dwell     <= '0;
         r_dcnt      <= '0;
         r_pcnt      <= '0;
         r_cont      <= 1'b0;
         r_first     <= 1'b0;
         r_stop_pend <= 1'b0;
         r_busy      <= 1'b0;
         r_cur_ch    <= 5'd0;
         r_ch_valid  <= 1'b0;
         r_done      <= 1'b0;
         r_cs_n      <= 1'b1;
         r_wr_n      <= 1'b1;
         r_en_n      <= 1'b1;
         r_addr      <= 5'd0;
      end else begin
         r_done     <= 1'b0;
         r_ch_valid <= 1'b0;
         if ((r_state != S_IDLE) && stop) r_stop_pend <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_stop_pend <= 1'b0;
               if (start && !stop) begin
                  r_mask  <= ch_mask;
                  r_dwell <= (dwell_ticks == '0) ? DWELL_W'(1) : dwell_ticks;
                  r_cont  <= continuous;
                  r_first <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               if (!w_end) begin
                  r_addr  <= w_up ? w_up_ch : w_wrap_ch;
                  r_cs_n  <= 1'b0;
                  r_first <= 1'b0;
                  r_pcnt  <= PH;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_phase_last) begin
                  r_wr_n  <= 1'b0;
                  r_pcnt  <= PH;
                  r_state <= S_STROBE;
               end else begin
                  r_pcnt <= r_pcnt - 8'd1;
               end
            end
            S_STROBE: begin
               if (w_phase_last) begin
                  r_wr_n  <= 1'b1;
                  r_pcnt  <= PH;
                  r_state <= S_HOLD;
               end else begin
                  r_pcnt <= r_pcnt - 8'd1;
               end
            end
            S_HOLD: begin
               if (w_phase_last) begin
                  // The device has latched by now, so cur_ch tracks it even on a stop.
                  r_cur_ch <= r_addr;
                  if (!w_stop) begin
                     r_cs_n     <= 1'b1;
                     r_en_n     <= 1'b0;
                     r_ch_valid <= 1'b1;
                     r_dcnt     <= r_dwell;
                     r_state    <= S_DWELL;
                  end
               end else begin
                  r_pcnt <= r_pcnt - 8'd1;
               end
            end
            S_DWELL: begin
               if (!w_stop) begin
                  if (r_dcnt == DWELL_W'(1)) r_state <= S_SEARCH;
                  else                       r_dcnt  <= r_dcnt - DWELL_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_end) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_en_n      <= 1'b1;
            r_stop_pend <= 1'b0;
         end
      end
   end

   assign busy     = r_busy;
   assign cur_ch   = r_cur_ch;
   assign ch_valid = r_ch_valid;
   assign done     = r_done;
   assign cs_n     = r_cs_n;
   assign wr_n     = r_wr_n;
   assign en_n     = r_en_n;
   assign addr     = r_addr;

endmodule

// File: tb/tb_adg732_scan_sequencer.sv
// Bench for adg732_scan_sequencer: a timeline model derived from channel-period arithmetic predicts every output each cycle.
module tb_adg732_scan_sequencer;

   localparam int PH = 2;
   localparam int DW = 24;
   localparam int BIG = 1 << 30;

   logic          clk = 1'b0;
   logic          rst, start, stop, continuous;
   logic [31:0]   ch_mask;
   logic [DW-1:0] dwell_ticks;
   logic          busy, ch_valid, done, cs_n, wr_n, en_n;
   logic [4:0]    cur_ch, addr;

   adg732_scan_sequencer #(.PHASE(PH), .DWELL_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
      .ch_mask(ch_mask), .dwell_ticks(dwell_ticks), .busy(busy), .cur_ch(cur_ch),
      .ch_valid(ch_valid), .done(done), .cs_n(cs_n), .wr_n(wr_n), .en_n(en_n), .addr(addr)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state: ascending channel list, channel period, done cycle, values left by the previous scan.
   int g_ch[32];
   int g_n, g_P, g_E, g_pa, g_pc, g_rst;

   logic       e_busy, e_valid, e_done, e_cs_n, e_wr_n, e_en_n;
   logic [4:0] e_cur, e_addr;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic cfg(input logic [31:0] mask, input int dw, input logic cont,
                      input int stop_at, input int rst_at);
      int d, e_nat, e_stop, rel, k, off;
      g_n = 0;
      for (int i = 0; i < 32; i++) if (mask[i]) begin g_ch[g_n] = i; g_n++; end
      d   = (dw == 0) ? 1 : dw;
      g_P = 1 + 3*PH + d;
      if (g_n == 0)  e_nat = 2;
      else if (!cont) e_nat = 2 + g_n*g_P;
      else            e_nat = BIG;
      e_stop = BIG;
      if (stop_at >= 1 && stop_at < e_nat) begin
         rel = stop_at - 1;
         k   = rel / g_P;
         off = rel % g_P;
         if (off >= 1 && off <= 3*PH) e_stop = 2 + k*g_P + 3*PH;
         else                         e_stop = stop_at + 1;
      end
      g_E   = imin(e_nat, e_stop);
      g_rst = rst_at;
      if (rst_at >= 0) g_E = BIG;
   endtask

   task automatic exp_at(input int t);
      int la, lc, rel, off;
      e_valid = 1'b0; e_done = 1'b0; e_busy = 1'b0;
      e_cs_n = 1'b1; e_wr_n = 1'b1; e_en_n = 1'b1;
      if (g_rst >= 0 && t > g_rst) begin
         e_cur = 5'd0; e_addr = 5'd0;
      end else if (t == 0) begin
         e_cur = 5'(g_pc); e_addr = 5'(g_pa);
      end else begin
         la = imin(t, g_E - 1);
         lc = imin(t, g_E);
         e_addr = (g_n > 0 && la >= 2) ? 5'(g_ch[((la-2)/g_P) % g_n]) : 5'(g_pa);
         e_cur  = (g_n > 0 && lc >= 2 + 3*PH) ? 5'(g_ch[((lc-2-3*PH)/g_P) % g_n]) : 5'(g_pc);
         if (t >= g_E) begin
            e_done = (t == g_E);
         end else begin
            rel     = t - 1;
            off     = rel % g_P;
            e_busy  = 1'b1;
            e_cs_n  = !(off >= 1 && off <= 3*PH);
            e_wr_n  = !(off >= PH+1 && off <= 2*PH);
            e_valid = (off == 3*PH + 1);
            e_en_n  = !(rel >= 3*PH + 1);
         end
      end
   endtask

   task automatic check_all(input int t);
      chk("busy",     t, 32'(busy),     32'(e_busy));
      chk("cur_ch",   t, 32'(cur_ch),   32'(e_cur));
      chk("ch_valid", t, 32'(ch_valid), 32'(e_valid));
      chk("done",     t, 32'(done),     32'(e_done));
      chk("cs_n",     t, 32'(cs_n),     32'(e_cs_n));
      chk("wr_n",     t, 32'(wr_n),     32'(e_wr_n));
      chk("en_n",     t, 32'(en_n),     32'(e_en_n));
      chk("addr",     t, 32'(addr),     32'(e_addr));
   endtask

   // Start at cycle 0; mid-scan the config inputs are scrambled to prove they were snapshotted.
   task automatic run(input logic [31:0] mask, input int dw, input logic cont,
                      input int stop_at, input int bs_at, input int rst_at);
      int tend, bs;
      cfg(mask, dw, cont, stop_at, rst_at);
      bs   = (bs_at >= g_E - 1) ? -1 : bs_at;
      tend = (rst_at >= 0) ? rst_at + 2 : g_E + 1;
      if (tend > 5000) begin
         n_assert++; n_fail++;
         $display("FAIL run_bound cycle=0 observed=%0d expected<=5000", tend);
         tend = 5000;
      end
      for (int t = 0; t <= tend; t++) begin
         @(negedge clk);
         exp_at(t);
         check_all(t);
         start = (t == 0) || (t == bs);
         stop  = (t == stop_at);
         rst   = (t == rst_at);
         if (t == 0) begin
            ch_mask = mask; dwell_ticks = DW'(dw); continuous = cont;
         end else begin
            ch_mask = $urandom; dwell_ticks = DW'($urandom_range(0, 7));
            continuous = 1'($urandom_range(0, 1));
         end
      end
      start = 1'b0; stop = 1'b0; rst = 1'b0;
      if (rst_at >= 0) begin
         g_pa = 0; g_pc = 0;
      end else begin
         exp_at(g_E);
         g_pa = int'(e_addr); g_pc = int'(e_cur);
      end
   endtask

   initial begin
      logic [31:0] m;
      int dw, sa;
      logic c;
      rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
      ch_mask = 32'hFFFF_FFFF; dwell_ticks = '0;
      g_pa = 0; g_pc = 0; g_rst = -1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 0, 32'(busy), 32'd0);
      chk("rst_cur",  0, 32'(cur_ch), 32'd0);
      chk("rst_vld",  0, 32'(ch_valid), 32'd0);
      chk("rst_done", 0, 32'(done), 32'd0);
      chk("rst_pins", 0, {29'd0, cs_n, wr_n, en_n}, 32'h7);
      chk("rst_addr", 0, 32'(addr), 32'd0);
      rst = 1'b0;

      run(32'h0000_0005, 3, 1'b0, -1, -1, -1);
      chk("two_ch_done_cycle", 0, 32'(g_E), 32'd22);
      run(32'h8000_0001, 1, 1'b1, 45, -1, -1);
      run(32'h0000_0000, 2, 1'b0, -1, -1, -1);
      run(32'h0000_0030, 2, 1'b0, 5, -1, -1);
      run(32'h0000_0412, 0, 1'b0, -1, 9, -1);
      run(32'h0000_0020, 1, 1'b1, 30, 12, -1);

      // start together with stop must not begin a scan.
      @(negedge clk);
      start = 1'b1; stop = 1'b1; ch_mask = 32'h1; dwell_ticks = DW'(1);
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("ss_busy", i, 32'(busy), 32'd0);
         chk("ss_cs_n", i, 32'(cs_n), 32'd1);
         chk("ss_done", i, 32'(done), 32'd0);
         @(negedge clk);
      end

      run(32'h0000_0104, 3, 1'b1, -1, -1, 9);
      run(32'h0000_0005, 1, 1'b0, -1, -1, -1);

      for (int r = 0; r < 8; r++) begin
         m  = $urandom & $urandom & $urandom;
         dw = $urandom_range(0, 4);
         c  = 1'($urandom_range(0, 1));
         if (c)                          sa = $urandom_range(1, 80);
         else if ($urandom_range(0, 1)) sa = $urandom_range(1, 60);
         else                           sa = -1;
         run(m, dw, c, sa, $urandom_range(1, 20), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
